// File: rtl/dcache_axi_bridge.sv
// AXI4 master bridge for the dcache refill/writeback port.
// Independent read and write FSMs, each with one transaction outstanding, and a same-line read-after-write stall.
module dcache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         bus_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

  function automatic logic is_line(input logic [2:0] t);
    return t == 3'b100;
  endfunction

  function automatic logic [7:0] burst_len(input logic [2:0] t);
    return is_line(t) ? 8'd3 : 8'd0;
  endfunction

  // Undefined encodings fall through to word size.
  function automatic logic [2:0] burst_size(input logic [2:0] t);
    case (t)
      3'b000:  return 3'd0;
      3'b001:  return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [31:0] burst_addr(input logic [2:0] t, input logic [31:0] a);
    return is_line(t) ? {a[31:4], 4'h0} : a;
  endfunction

  rstate_t        rstate, rstate_nxt;
  wstate_t        wstate, wstate_nxt;
  logic [1:0]     cnt, cnt_nxt;
  logic [31:0]    rd_addr_q, wr_addr_q;
  logic [2:0]     rd_type_q, wr_type_q;
  logic [3:0]     wr_strb_q;
  logic [127:0]   wr_data_q;
  logic           raw_hazard, rd_accept, wr_accept;

  // A pending or same-cycle write to the same line blocks the read until the B handshake.
  assign raw_hazard = (wstate != W_IDLE && wr_addr_q[31:4] == rd_addr[31:4]) ||
                      (wstate == W_IDLE && wr_req && wr_addr[31:4] == rd_addr[31:4]);
  assign rd_rdy    = !rst && rstate == R_IDLE && !raw_hazard;
  assign wr_rdy    = !rst && wstate == W_IDLE;
  assign rd_accept = rd_req && rd_rdy;
  assign wr_accept = wr_req && wr_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate <= R_IDLE;
      wstate <= W_IDLE;
      cnt    <= 2'd0;
    end else begin
      rstate <= rstate_nxt;
      wstate <= wstate_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Request payload is captured whole so dcache can move on immediately.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      rd_addr_q <= rd_addr;
      rd_type_q <= rd_type;
    end
    if (wr_accept) begin
      wr_addr_q <= wr_addr;
      wr_type_q <= wr_type;
      wr_strb_q <= wr_wstrb;
      wr_data_q <= wr_data;
    end
  end

  always_comb begin
    rstate_nxt = rstate;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (rstate)
      R_IDLE: if (rd_accept) rstate_nxt = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_nxt = wstate;
    cnt_nxt    = cnt;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (wstate)
      W_IDLE: if (wr_accept) wstate_nxt = W_AW;
      W_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          wstate_nxt = W_DATA;
          cnt_nxt    = 2'd0;
        end
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready) begin
          cnt_nxt = cnt + 2'd1;
          if (wlast) wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  assign arid    = AXI_ID;
  assign araddr  = burst_addr(rd_type_q, rd_addr_q);
  assign arlen   = burst_len(rd_type_q);
  assign arsize  = burst_size(rd_type_q);
  assign arburst = 2'b01;

  assign awid    = AXI_ID;
  assign awaddr  = burst_addr(wr_type_q, wr_addr_q);
  assign awlen   = burst_len(wr_type_q);
  assign awsize  = burst_size(wr_type_q);
  assign awburst = 2'b01;

  assign wdata = wr_data_q[{cnt, 5'd0} +: 32];
  assign wstrb = is_line(wr_type_q) ? 4'hF : wr_strb_q;
  assign wlast = is_line(wr_type_q) ? (cnt == 2'd3) : 1'b1;

  assign ret_valid = rstate == R_DATA && rvalid;
  assign ret_last  = rstate == R_DATA && rvalid && rlast;
  assign ret_data  = rdata;

  assign bus_err = (rstate == R_DATA && rvalid && rresp != 2'b00) ||
                   (wstate == W_RESP && bvalid && bresp != 2'b00);

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: the bench plays the AXI slave cycle by cycle.
module tb_dcache_axi_bridge;
  logic clk = 1'b0, rst;
  logic rd_req, rd_rdy, ret_valid, ret_last;
  logic [2:0] rd_type, wr_type;
  logic [31:0] rd_addr, ret_data, wr_addr;
  logic wr_req, wr_rdy, bus_err;
  logic [3:0] wr_wstrb;
  logic [127:0] wr_data;
  logic [3:0] arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;

  int checks = 0;
  int failures = 0;

  dcache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    rst = 1'b1;
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h40; wr_wstrb = 4'h0; wr_data = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b1;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b1;

    // Reset: all handshake outputs quiet even with requests and slave valids driven.
    #2;
    check("rst_rd_rdy", rd_rdy, 0);
    check("rst_wr_rdy", wr_rdy, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_ret_valid", ret_valid, 0);
    check("rst_bus_err", bus_err, 0);
    step();
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rvalid = 1'b0; bvalid = 1'b0;

    // 1: line read, 4 beats.
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1C00_0014;
    settle(); check("t1_rd_rdy", rd_rdy, 1);
    step(); rd_req = 1'b0; arready = 1'b1;
    settle();
    check("t1_arvalid", arvalid, 1);
    check("t1_araddr", araddr, 32'h1C00_0010);
    check("t1_arlen", arlen, 3);
    check("t1_arsize", arsize, 2);
    check("t1_arburst", arburst, 1);
    check("t1_arid", arid, 1);
    step(); arready = 1'b0;
    settle(); check("t1_arvalid_drop", arvalid, 0);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'hA0 + i; rlast = (i == 3);
      settle();
      check("t1_ret_valid", ret_valid, 1);
      check("t1_ret_data", ret_data, 32'hA0 + i);
      check("t1_ret_last", ret_last, (i == 3));
      check("t1_rready", rready, 1);
      check("t1_rd_rdy_busy", rd_rdy, 0);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check("t1_ret_valid_end", ret_valid, 0);
    check("t1_rd_rdy_back", rd_rdy, 1);
    step();

    // 2: line write, wready stalled 2 cycles per beat, payload captured at accept.
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h8000_0040; wr_wstrb = 4'h0;
    wr_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    settle(); check("t2_wr_rdy", wr_rdy, 1);
    step(); wr_req = 1'b0; wr_data = {4{32'hBAD0BAD0}}; awready = 1'b1;
    settle();
    check("t2_awvalid", awvalid, 1);
    check("t2_awaddr", awaddr, 32'h8000_0040);
    check("t2_awlen", awlen, 3);
    check("t2_awsize", awsize, 2);
    check("t2_awid", awid, 1);
    check("t2_wr_rdy_busy", wr_rdy, 0);
    step(); awready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 3; s++) begin
        wready = (s == 2);
        settle();
        check("t2_wvalid", wvalid, 1);
        check("t2_wdata", wdata, 32'(32'h11111111 * (b + 1)));
        check("t2_wstrb", wstrb, 4'hF);
        check("t2_wlast", wlast, (b == 3));
        check("t2_wr_rdy_data", wr_rdy, 0);
        step();
      end
    end
    wready = 1'b0;
    settle();
    check("t2_wvalid_drop", wvalid, 0);
    check("t2_bready", bready, 1);
    step(); bvalid = 1'b1;
    settle();
    check("t2_wr_rdy_bvalid", wr_rdy, 0);
    check("t2_bus_err_ok", bus_err, 0);
    step(); bvalid = 1'b0;
    settle(); check("t2_wr_rdy_back", wr_rdy, 1);
    step();

    // 3: byte write, single beat; also an error B response.
    wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h100; wr_wstrb = 4'b0100;
    wr_data = {96'h0, 32'hDEAD_BEEF};
    step(); wr_req = 1'b0; awready = 1'b1;
    settle();
    check("t3_awaddr", awaddr, 32'h100);
    check("t3_awlen", awlen, 0);
    check("t3_awsize", awsize, 0);
    step(); awready = 1'b0; wready = 1'b1;
    settle();
    check("t3_wvalid", wvalid, 1);
    check("t3_wlast", wlast, 1);
    check("t3_wstrb", wstrb, 4'b0100);
    check("t3_wdata", wdata, 32'hDEAD_BEEF);
    step(); wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    settle();
    check("t3_bready", bready, 1);
    check("t3_bus_err", bus_err, 1);
    step(); bvalid = 1'b0; bresp = 2'b00;
    settle(); check("t3_bus_err_pulse", bus_err, 0);
    step();

    // 4: read-after-write hazard on line 0x200; other line passes.
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h200; wr_data = {4{32'h5A5A5A5A}};
    step(); wr_req = 1'b0;
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h208;
    settle(); check("t4_haz_aw", rd_rdy, 0);
    step(); awready = 1'b1; rd_addr = 32'h300;
    settle(); check("t4_other_line", rd_rdy, 1);
    step(); awready = 1'b0; rd_req = 1'b0; arready = 1'b1; wready = 1'b1;
    settle();
    check("t4_araddr", araddr, 32'h300);
    check("t4_arlen", arlen, 0);
    step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
    settle();
    check("t4_ret_data", ret_data, 32'h55);
    check("t4_ret_last", ret_last, 1);
    step(); rvalid = 1'b0; rlast = 1'b0; rd_req = 1'b1; rd_addr = 32'h208;
    settle(); check("t4_haz_data", rd_rdy, 0);
    step();
    settle();
    check("t4_wlast", wlast, 1);
    check("t4_haz_last", rd_rdy, 0);
    step(); wready = 1'b0;
    settle(); check("t4_haz_resp", rd_rdy, 0);
    step(); bvalid = 1'b1;
    settle(); check("t4_haz_bvalid", rd_rdy, 0);
    step(); bvalid = 1'b0;
    settle(); check("t4_haz_clear", rd_rdy, 1);
    step(); rd_req = 1'b0; arready = 1'b1;
    settle(); check("t4_araddr_208", araddr, 32'h208);
    step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
    step(); rvalid = 1'b0; rlast = 1'b0;

    // 5a: simultaneous requests to different lines.
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h400;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h500; wr_wstrb = 4'hF;
    settle();
    check("t5_rd_rdy", rd_rdy, 1);
    check("t5_wr_rdy", wr_rdy, 1);
    step(); rd_req = 1'b0; wr_req = 1'b0;
    settle();
    check("t5_arvalid", arvalid, 1);
    check("t5_awvalid", awvalid, 1);
    arready = 1'b1; awready = 1'b1;
    step(); arready = 1'b0; awready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; wready = 1'b1;
    step(); rvalid = 1'b0; rlast = 1'b0; wready = 1'b0; bvalid = 1'b1;
    step(); bvalid = 1'b0;

    // 5b: same line from idle: write wins, read waits for B.
    rd_req = 1'b1; rd_addr = 32'h600;
    wr_req = 1'b1; wr_addr = 32'h604;
    settle();
    check("t5s_wr_rdy", wr_rdy, 1);
    check("t5s_rd_rdy", rd_rdy, 0);
    step(); wr_req = 1'b0;
    settle();
    check("t5s_awvalid", awvalid, 1);
    check("t5s_arvalid", arvalid, 0);
    check("t5s_rd_rdy_aw", rd_rdy, 0);
    awready = 1'b1;
    step(); awready = 1'b0; wready = 1'b1;
    step(); wready = 1'b0; bvalid = 1'b1;
    step(); bvalid = 1'b0;
    settle(); check("t5s_rd_rdy_free", rd_rdy, 1);
    step(); rd_req = 1'b0; arready = 1'b1;
    settle(); check("t5s_araddr", araddr, 32'h600);
    step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
    step(); rvalid = 1'b0; rlast = 1'b0;

    // 6: reset in R_DATA after beat 2, then a clean read with one SLVERR beat.
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1000;
    step(); rd_req = 1'b0; arready = 1'b1;
    step(); arready = 1'b0; rvalid = 1'b1;
    step();
    step();
    rst = 1'b1;
    settle();
    check("t6_rst_rready", rready, 0);
    check("t6_rst_ret_valid", ret_valid, 0);
    check("t6_rst_arvalid", arvalid, 0);
    check("t6_rst_rd_rdy", rd_rdy, 0);
    step(); rst = 1'b0; rvalid = 1'b0;
    settle(); check("t6_rd_rdy_after", rd_rdy, 1);
    rd_req = 1'b1; rd_addr = 32'h2004;
    step(); rd_req = 1'b0; arready = 1'b1;
    settle(); check("t6_araddr", araddr, 32'h2000);
    step(); arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'hC0 + i; rlast = (i == 3); rresp = (i == 1) ? 2'b10 : 2'b00;
      settle();
      check("t6_ret_data", ret_data, 32'hC0 + i);
      check("t6_bus_err", bus_err, (i == 1));
      check("t6_ret_last", ret_last, (i == 3));
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    settle();
    check("t6_rd_rdy_end", rd_rdy, 1);
    check("t6_bus_err_end", bus_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
